// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-op sequencer: ALUOp encodings, FSM state
// codes and small op-classification helpers.
package alu_pkg;

    localparam int unsigned OP_W = 4;
    localparam int unsigned ST_W = 3;

    // op_req / ALUOp encodings
    localparam logic [OP_W-1:0] OP_NOP    = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD    = 4'h1;
    localparam logic [OP_W-1:0] OP_ADDU   = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB    = 4'h3;
    localparam logic [OP_W-1:0] OP_SUBU   = 4'h4;
    localparam logic [OP_W-1:0] OP_AND    = 4'h5;
    localparam logic [OP_W-1:0] OP_OR     = 4'h6;
    localparam logic [OP_W-1:0] OP_SLT    = 4'h7;
    localparam logic [OP_W-1:0] OP_SHLOAD = 4'h8;
    localparam logic [OP_W-1:0] OP_SLL    = 4'h9;
    localparam logic [OP_W-1:0] OP_SRL    = 4'hA;
    localparam logic [OP_W-1:0] OP_SRA    = 4'hB;
    localparam logic [OP_W-1:0] OP_BEQ    = 4'hC;
    localparam logic [OP_W-1:0] OP_BNE    = 4'hD;
    localparam logic [OP_W-1:0] OP_PASSA  = 4'hE;

    // Sequencer states
    localparam logic [ST_W-1:0] S_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] S_ISSUE   = 3'd1;
    localparam logic [ST_W-1:0] S_SH_LOAD = 3'd2;
    localparam logic [ST_W-1:0] S_SH_RUN  = 3'd3;
    localparam logic [ST_W-1:0] S_CAPTURE = 3'd4;
    localparam logic [ST_W-1:0] S_FINISH  = 3'd5;

    // Ops that go through the clocked shifter sequence
    function automatic logic is_shift(input logic [OP_W-1:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // Ops whose signed overflow may raise an exception
    function automatic logic is_trapping(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // SHLOAD is internal-only and 4'hF is unassigned; both behave as NOP
    function automatic logic is_known(input logic [OP_W-1:0] op);
        return (op != OP_SHLOAD) && (op != 4'hF);
    endfunction

endpackage

// File: rtl/alu_seq_fsm.sv
// Sequencer control: state register, shift-cycle counter and latched op.
// Ports: clk, rst_n (async active-low), start_i/op_req_i (request),
//        state_o/state_next_o (current/next state), op_o/op_next_o
//        (current/next latched op code).
module alu_seq_fsm
    import alu_pkg::*;
#(
    parameter int unsigned SHIFT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [OP_W-1:0] op_req_i,
    output logic [ST_W-1:0] state_o,
    output logic [ST_W-1:0] state_next_o,
    output logic [OP_W-1:0] op_o,
    output logic [OP_W-1:0] op_next_o
);

    localparam int unsigned CW = $clog2(SHIFT_CYCLES) + 1;

    logic [ST_W-1:0] state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [OP_W-1:0] op_q, op_d;

    // State, counter and op registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NOP;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_d    = is_known(op_req_i) ? op_req_i : OP_NOP;
                    state_d = is_shift(op_req_i) ? S_SH_LOAD : S_ISSUE;
                end
            end
            S_ISSUE:   state_d = S_CAPTURE;
            S_SH_LOAD: begin
                state_d = S_SH_RUN;
                cnt_d   = CW'(SHIFT_CYCLES - 1);
            end
            // Shift code is held for SHIFT_CYCLES cycles in total
            S_SH_RUN: begin
                if (cnt_q == '0) state_d = S_CAPTURE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_CAPTURE: state_d = S_FINISH;
            S_FINISH:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign state_o      = state_q;
    assign state_next_o = state_d;
    assign op_o         = op_q;
    assign op_next_o    = op_d;

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives ALUOp to the multicycle ALU unit, captures its result and flags,
// and returns a registered result with a done pulse.
// Ports: clk, reset (async active-low), start/op_req (request),
//        ALUOp (to ALU), ALUOut_in/OVERFLOW_in/ZERO_in/Update_UC_in (from ALU),
//        busy, done, result, zero_q, branch_taken, ovf_exc (to control FSM).
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned SHIFT_CYCLES = 2,
    parameter bit          TRAP_ON_OVF  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op_req,
    output logic [3:0]  ALUOp,
    input  logic [31:0] ALUOut_in,
    input  logic        OVERFLOW_in,
    input  logic        ZERO_in,
    input  logic        Update_UC_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        zero_q,
    output logic        branch_taken,
    output logic        ovf_exc
);

    logic [ST_W-1:0] state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;

    logic [OP_W-1:0] aluop_q, aluop_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ovf_exc_q, ovf_exc_d;
    logic            ovf_arm_q, ovf_arm_d;
    logic [31:0]     result_q, result_d;
    logic            zero_flag_q, zero_flag_d;
    logic            branch_q, branch_d;
    logic            trap_c;

    alu_seq_fsm #(
        .SHIFT_CYCLES (SHIFT_CYCLES)
    ) u_fsm (
        .clk          (clk),
        .rst_n        (reset),
        .start_i      (start),
        .op_req_i     (op_req),
        .state_o      (state_q),
        .state_next_o (state_d),
        .op_o         (op_q),
        .op_next_o    (op_d)
    );

    assign trap_c = TRAP_ON_OVF && is_trapping(op_q) && OVERFLOW_in;

    // Output flops are loaded from the next state so they line up with it
    always_comb begin
        aluop_d     = OP_NOP;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_q == S_FINISH);
        ovf_exc_d   = done_d & ovf_arm_q;
        ovf_arm_d   = ovf_arm_q;
        result_d    = result_q;
        zero_flag_d = zero_flag_q;
        branch_d    = branch_q;

        case (state_d)
            S_ISSUE, S_SH_RUN, S_CAPTURE: aluop_d = op_d;
            S_SH_LOAD:                    aluop_d = OP_SHLOAD;
            default:                      aluop_d = OP_NOP;
        endcase

        // Sample the ALU; a trapped overflow keeps the previous result
        if (state_q == S_CAPTURE) begin
            ovf_arm_d = trap_c;
            if (op_q == OP_NOP) begin
                zero_flag_d = 1'b0;
                branch_d    = 1'b0;
            end else begin
                zero_flag_d = ZERO_in;
                branch_d    = Update_UC_in;
                if (!trap_c) result_d = ALUOut_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aluop_q     <= OP_NOP;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_exc_q   <= 1'b0;
            ovf_arm_q   <= 1'b0;
            result_q    <= 32'h0;
            zero_flag_q <= 1'b0;
            branch_q    <= 1'b0;
        end else begin
            aluop_q     <= aluop_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_exc_q   <= ovf_exc_d;
            ovf_arm_q   <= ovf_arm_d;
            result_q    <= result_d;
            zero_flag_q <= zero_flag_d;
            branch_q    <= branch_d;
        end
    end

    assign ALUOp        = aluop_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign ovf_exc      = ovf_exc_q;
    assign result       = result_q;
    assign zero_q       = zero_flag_q;
    assign branch_taken = branch_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer (default parameters).
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op_req;
    logic [3:0]  ALUOp;
    logic [31:0] ALUOut_in;
    logic        OVERFLOW_in;
    logic        ZERO_in;
    logic        Update_UC_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero_q;
    logic        branch_taken;
    logic        ovf_exc;

    int n_tests = 0;
    int n_fail  = 0;

    alu_op_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op_req       (op_req),
        .ALUOp        (ALUOp),
        .ALUOut_in    (ALUOut_in),
        .OVERFLOW_in  (OVERFLOW_in),
        .ZERO_in      (ZERO_in),
        .Update_UC_in (Update_UC_in),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .zero_q       (zero_q),
        .branch_taken (branch_taken),
        .ovf_exc      (ovf_exc)
    );

    always #5 clk = ~clk;

    // Issue one request from a negedge; observe ALUOp/busy at each following
    // negedge (k = edges after the accepting edge) until done, bounded.
    // Returns at the negedge where done is high, or lat = -1 on timeout.
    task automatic run_op(input logic [3:0] op, output int lat,
                          output logic [7:0][3:0] seq, output logic [7:0] bseq);
        lat  = -1;
        seq  = '0;
        bseq = '0;
        start  = 1'b1;
        op_req = op;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k < 8) begin
                seq[k]  = ALUOp;
                bseq[k] = busy;
            end
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op_req = 4'h0;
        ALUOut_in = 32'h0; OVERFLOW_in = 1'b0; ZERO_in = 1'b0; Update_UC_in = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (ALUOp !== 4'h0) begin n_fail++; $display("FAIL reset_aluop: got %0h want 0", ALUOp); end
        n_tests++; if ({busy, done, ovf_exc, zero_q, branch_taken} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {busy, done, ovf_exc, zero_q, branch_taken}); end
        n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        int lat; logic [7:0][3:0] seq; logic [7:0] bseq;
        ALUOut_in = 32'd12; OVERFLOW_in = 1'b0; ZERO_in = 1'b0; Update_UC_in = 1'b0;
        run_op(4'd1, lat, seq, bseq);
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL add_latency: got %0d want 3", lat); end
        n_tests++; if ({seq[0], seq[1], seq[2]} !== {4'd1, 4'd1, 4'd0}) begin n_fail++; $display("FAIL add_aluop_seq: got %h %h %h want 1 1 0", seq[0], seq[1], seq[2]); end
        n_tests++; if (bseq[3:0] !== 4'b0111) begin n_fail++; $display("FAIL add_busy_seq: got %b want 0111", bseq[3:0]); end
        n_tests++; if (result !== 32'd12) begin n_fail++; $display("FAIL add_result: got %0d want 12", result); end
        n_tests++; if (ovf_exc !== 1'b0) begin n_fail++; $display("FAIL add_ovf_exc: got %b want 0", ovf_exc); end
        @(negedge clk);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_overflow();
        int lat; logic [7:0][3:0] seq; logic [7:0] bseq;
        ALUOut_in = 32'h8000_0000; OVERFLOW_in = 1'b1;
        run_op(4'd1, lat, seq, bseq);
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL ovf_latency: got %0d want 3", lat); end
        n_tests++; if (ovf_exc !== 1'b1) begin n_fail++; $display("FAIL ovf_exc_add: got %b want 1", ovf_exc); end
        n_tests++; if (result !== 32'd12) begin n_fail++; $display("FAIL ovf_result_kept: got %h want c", result); end
        @(negedge clk);
        n_tests++; if (ovf_exc !== 1'b0) begin n_fail++; $display("FAIL ovf_exc_pulse: got %b want 0", ovf_exc); end
        run_op(4'd2, lat, seq, bseq);
        n_tests++; if (ovf_exc !== 1'b0) begin n_fail++; $display("FAIL addu_no_trap: got %b want 0", ovf_exc); end
        n_tests++; if (result !== 32'h8000_0000) begin n_fail++; $display("FAIL addu_result: got %h want 80000000", result); end
        ALUOut_in = 32'h7FFF_FFFF;
        run_op(4'd3, lat, seq, bseq);
        n_tests++; if ({ovf_exc, result} !== {1'b1, 32'h8000_0000}) begin n_fail++; $display("FAIL sub_trap: got %b/%h want 1/80000000", ovf_exc, result); end
        OVERFLOW_in = 1'b0;
    endtask

    task automatic test_shift();
        int lat; logic [7:0][3:0] seq; logic [7:0] bseq;
        ALUOut_in = 32'h10;
        run_op(4'd9, lat, seq, bseq);
        n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL sll_latency: got %0d want 5", lat); end
        n_tests++; if ({seq[0], seq[1], seq[2], seq[3], seq[4]} !== {4'd8, 4'd9, 4'd9, 4'd9, 4'd0}) begin n_fail++; $display("FAIL sll_aluop_seq: got %h %h %h %h %h want 8 9 9 9 0", seq[0], seq[1], seq[2], seq[3], seq[4]); end
        n_tests++; if (result !== 32'h10) begin n_fail++; $display("FAIL sll_result: got %h want 10", result); end
    endtask

    task automatic test_branch();
        int lat; logic [7:0][3:0] seq; logic [7:0] bseq;
        ALUOut_in = 32'h0; ZERO_in = 1'b1; Update_UC_in = 1'b1;
        run_op(4'd12, lat, seq, bseq);
        n_tests++; if ({branch_taken, zero_q} !== 2'b11) begin n_fail++; $display("FAIL beq_flags: got %b want 11", {branch_taken, zero_q}); end
        ALUOut_in = 32'h0000_0004; ZERO_in = 1'b0; Update_UC_in = 1'b0;
        run_op(4'd13, lat, seq, bseq);
        n_tests++; if ({branch_taken, zero_q} !== 2'b00) begin n_fail++; $display("FAIL bne_flags: got %b want 00", {branch_taken, zero_q}); end
        n_tests++; if (result !== 32'h4) begin n_fail++; $display("FAIL bne_result: got %h want 4", result); end
    endtask

    task automatic test_unknown();
        int lat; logic [7:0][3:0] seq; logic [7:0] bseq;
        ZERO_in = 1'b1; Update_UC_in = 1'b1;
        run_op(4'd12, lat, seq, bseq);
        ALUOut_in = 32'hDEAD_BEEF;
        run_op(4'hF, lat, seq, bseq);
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL unk_latency: got %0d want 3", lat); end
        n_tests++; if (seq[0] !== 4'd0) begin n_fail++; $display("FAIL unk_aluop: got %h want 0", seq[0]); end
        n_tests++; if (result !== 32'h0000_0004) begin n_fail++; $display("FAIL unk_result: got %h want 4", result); end
        n_tests++; if ({branch_taken, zero_q} !== 2'b00) begin n_fail++; $display("FAIL unk_flags: got %b want 00", {branch_taken, zero_q}); end
        ZERO_in = 1'b0; Update_UC_in = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [11:0] done_v, busy_v;
        ALUOut_in = 32'h55;
        start = 1'b1; op_req = 4'd1;
        @(posedge clk);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            done_v[k] = done;
            busy_v[k] = busy;
        end
        start = 1'b0;
        n_tests++; if (done_v !== 12'b1000_1000_1000) begin n_fail++; $display("FAIL b2b_done: got %b want 100010001000", done_v); end
        n_tests++; if (busy_v !== 12'b0111_0111_0111) begin n_fail++; $display("FAIL b2b_busy: got %b want 011101110111", busy_v); end
        n_tests++; if (result !== 32'h55) begin n_fail++; $display("FAIL b2b_result: got %h want 55", result); end
    endtask

    task automatic test_reset_mid();
        int lat; int seen; logic [7:0][3:0] seq; logic [7:0] bseq;
        ALUOut_in = 32'hAAAA;
        start = 1'b1; op_req = 4'd10;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_tests++; if (ALUOp !== 4'd10) begin n_fail++; $display("FAIL rst_mid_in_run: got %h want a", ALUOp); end
        #1 reset = 1'b0;
        #1;
        n_tests++; if ({ALUOp, busy, done, ovf_exc} !== 7'b0) begin n_fail++; $display("FAIL rst_mid_async: got %h/%b%b%b want 0/000", ALUOp, busy, done, ovf_exc); end
        n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL rst_mid_result: got %h want 0", result); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done !== 1'b0) seen++;
        end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d done cycles want 0", seen); end
        ALUOut_in = 32'hF000_0000;
        run_op(4'd11, lat, seq, bseq);
        n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL sra_latency: got %0d want 5", lat); end
        n_tests++; if ({seq[0], seq[1]} !== {4'd8, 4'd11}) begin n_fail++; $display("FAIL sra_aluop_seq: got %h %h want 8 b", seq[0], seq[1]); end
        n_tests++; if (result !== 32'hF000_0000) begin n_fail++; $display("FAIL sra_result: got %h want f0000000", result); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_shift();
        test_branch();
        test_unknown();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the ALU-unit interface in the multicycle MIPS datapath.
- Accepts one decoded arithmetic, logic, shift or branch-compare request from the main control FSM and drives the 4-bit ALUOp code cycle by cycle, including the multi-cycle clocked-shifter sequence.
- Captures ALUOut and the flags (OVERFLOW, ZERO, Update_UC) and returns one registered result with a done pulse.
- Converts signed overflow into an exception request.

Parameters:
- SHIFT_CYCLES, 2: cycles ALUOp holds a shift code before the shifter output is sampled (minimum 1).
- TRAP_ON_OVF, 1: when 1, signed ADD/SUB overflow raises ovf_exc and suppresses the result write.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 forces the reset state immediately.
- start  in  1  request strobe; sampled only in IDLE.
- op_req  in  4  requested operation, encoding from the shared package.
- ALUOp  out  4  operation code to the ALU unit; registered.
- ALUOut_in  in  32  ALU unit result.
- OVERFLOW_in  in  1  ALU unit overflow flag.
- ZERO_in  in  1  ALU unit zero flag.
- Update_UC_in  in  1  ALU unit branch-compare result.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; result and flags are valid that cycle.
- result  out  32  captured result; holds until the next done.
- zero_q  out  1  captured ZERO.
- branch_taken  out  1  captured Update_UC; meaningful only for BEQ/BNE requests.
- ovf_exc  out  1  one-cycle pulse, coincident with done, on trapped overflow.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state IDLE;
  - ALUOp=NOP (4'h0);
  - busy, done, ovf_exc, zero_q and branch_taken all 0;
  - result = 32'h0.
- States: IDLE, ISSUE, SH_LOAD, SH_RUN, CAPTURE, FINISH.
- IDLE: ALUOp=NOP. On start=1, latch op_req and go to ISSUE for non-shift ops or SH_LOAD for SLL/SRL/SRA. start is ignored in every other state; no queueing.
- ISSUE: ALUOp = the latched code (combinational ALU path settles), then go to CAPTURE.
- SH_LOAD: ALUOp=SHLOAD (shifter loads B), then go to SH_RUN with counter = SHIFT_CYCLES-1.
- SH_RUN: ALUOp = the shift code. Decrement the counter each cycle; on 0 go to CAPTURE.
- CAPTURE: ALUOp holds the last code.
  - Sample ALUOut_in, ZERO_in and Update_UC_in into registers; go to FINISH.
  - If the op is ADD or SUB and OVERFLOW_in=1 and TRAP_ON_OVF=1: result is not updated and ovf_exc is armed.
  - ADDU/SUBU never trap; their overflow is ignored.
- FINISH: done=1 (and ovf_exc=1 if armed), ALUOp=NOP, busy=0 on the next cycle; return to IDLE.
- Latency, start edge to done-high edge:
  - non-shift ops: 3 cycles;
  - shifts: 4+SHIFT_CYCLES-1 cycles (5 at default).
- A start that is high during FINISH is not accepted. A new request may be accepted on the first IDLE cycle after done.
- Reset asserted mid-operation aborts immediately: done and ovf_exc are never emitted for the aborted request, and result returns to 0.
- Unknown op_req codes are treated as NOP: pass through ISSUE/CAPTURE, done pulses, result is unchanged, flags are cleared.
- Widths: all 32-bit data is pass-through; no arithmetic is performed in this block except the internal counter, width clog2(SHIFT_CYCLES)+1.

Decomposition:
- Shared package alu_pkg holds:
  - the op_req/ALUOp encodings: NOP=0, ADD=1, ADDU=2, SUB=3, SUBU=4, AND=5, OR=6, SLT=7, SHLOAD=8, SLL=9, SRL=10, SRA=11, BEQ=12, BNE=13, PASSA=14;
  - the state enum;
  - helper constants is_shift and is_trapping.
- One sub-module is natural: alu_seq_fsm (state register, counter, next-state logic). The top level holds the capture registers and output flops.

Test Plan:
- ADD of 5 and 7 (ALU model returns 12, OVERFLOW=0) -> ALUOp sequence 1,1 then 0; done 3 cycles after start; result=32'd12; ovf_exc=0.
- ADD with ALU model OVERFLOW=1 (0x7FFFFFFF + 1) -> done and ovf_exc pulse together; result keeps the previous 12. Repeat as ADDU -> result=0x80000000 and no ovf_exc.
- SLL (ALU model returns 0x10 after SH_RUN) -> ALUOp sequence 8,9,9 then capture; done 5 cycles after start; result=0x10.
- BEQ with Update_UC_in=1 and ZERO_in=1 -> branch_taken=1 and zero_q=1 at done. BNE with Update_UC_in=0 -> branch_taken=0.
- start held high continuously -> requests are accepted only in IDLE, one done per request, busy low for exactly one cycle between requests.
- reset driven low during SH_RUN -> outputs return to reset values asynchronously; no done pulse. After release, an SRA request completes normally.
